// File: rtl/regfile_write_port_if.sv
// Write-request channel of the register file.
// Requester drives valid/addr/data and watches ready.
interface regfile_write_port_if #(
  parameter int WIDTH = 64
);
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/regfile_write_port.sv
// Write side of the 32 x 64 register file with a sweep clear engine.
// Optional macro REGFILE_WRITE_BYPASS_EN: same-cycle write bypass onto q.
module regfile_write_port #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                        clk,
  input  logic                        reset,
  regfile_write_port_if.slave         wr,
  input  logic                        clr_req,
  output logic                        clr_busy,
  output logic                        clr_done,
  output logic [DEPTH-1:0][WIDTH-1:0] q
);

  localparam int CW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] st [DEPTH];

  assign wr.wr_ready = (state == IDLE);
  assign accept      = wr.wr_valid && (state == IDLE);
  assign last        = (cnt == CW'(DEPTH - 1));

  // Clear sequencer: sweep counter, busy flag and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (last) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // One storage word per index; the zero register has no flop at all.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      assign st[g] = '0;
    end else begin : g_flop
      logic we;
      logic ce;
      assign we = accept && (wr.wr_addr == 5'(g));
      assign ce = (state == CLEAR) && (cnt == CW'(g));
      // Sweep clear wins; otherwise load on a decoded write hit.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          st[g] <= '0;
        end else if (ce) begin
          st[g] <= '0;
        end else if (we) begin
          st[g] <= wr.wr_data;
        end
      end
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic in_range;
  assign in_range = {1'b0, wr.wr_addr} < 6'(DEPTH);

  // Present storage, with the in-flight write forwarded to its slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q[i] = st[i];
    end
    if (accept && in_range &&
        (wr.wr_addr != 5'(ZERO_REG))) begin
      q[wr.wr_addr] = wr.wr_data;
    end
  end
`else
  // Present storage contents to the read muxes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q[i] = st[i];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench for regfile_write_port.
// Write results and clear-done pulses are checked by a monitor.
module tb_regfile_write_port;

  logic              clk = 1'b0;
  logic              reset;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic [31:0][63:0] q;

  regfile_write_port_if #(.WIDTH(64)) bus ();

  regfile_write_port dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (bus),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .q        (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } wexp_t;

  int          errors = 0;
  int          checks = 0;
  wexp_t       exp_q[$];
  int          done_q[$];
  logic [63:0] mdl [32];
  bit          fire;
  logic [4:0]  fire_addr;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_all(string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (q[i] !== mdl[i]) bad++;
    chk(name, 64'(bad), 64'd0);
  endtask

  // Monitor: pops expected write results and clear-done events.
  initial begin
    fire = 1'b0;
    forever begin
      @(posedge clk);
      fire      = bus.wr_valid && bus.wr_ready && !reset;
      fire_addr = bus.wr_addr;
      #2;
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d want none",
                   fire_addr);
        end else begin
          wexp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(fire_addr), 64'(e.addr));
          chk("wr_q", q[e.addr], e.data);
        end
      end
      if (clr_done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_clr_done: got 1 want 0");
        end else begin
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic wait_accept(string name);
    for (int n = 0; ; n++) begin
      @(posedge clk);
      if (bus.wr_ready && !reset) break;
      if (n == 50) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no accept want accept", name);
        break;
      end
    end
  endtask

  task automatic do_write(logic [4:0] a, logic [63:0] d);
    wexp_t       e;
    e.addr = a;
    e.data = (a == 5'd31) ? 64'd0 : d;
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    exp_q.push_back(e);
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    chk("bypass_pre_edge", q[a], e.data);
`else
    chk("pre_edge", q[a], mdl[a]);
`endif
    wait_accept("write");
    mdl[a] = e.data;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    wexp_t e;
    #100000;
    e.addr = '0;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    wexp_t e;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    reset        = 1'b1;
    clr_req      = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset_q");
    chk("reset_busy", 64'(clr_busy), 64'd0);
    chk("reset_done", 64'(clr_done), 64'd0);
    chk("reset_ready", 64'(bus.wr_ready), 64'd1);
    reset = 1'b0;

    // Basic write and zero-register discard.
    do_write(5'd5, 64'hDEAD_BEEF_0123_4567);
    chk_all("w5_others");
    do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w31_zero", q[31], 64'd0);
    do_write(5'd0, 64'h1111_2222_3333_4444);
    do_write(5'd30, 64'h9999_AAAA_BBBB_CCCC);
    chk_all("w0_w30");

    // Fill then sweep clear.
    for (int i = 0; i < 31; i++)
      do_write(5'(i), 64'(i + 1));
    chk_all("fill");
    done_q.push_back(1);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) mdl[k-1] = '0;
      chk("sweep_busy", 64'(clr_busy), 64'd1);
      chk("sweep_ready", 64'(bus.wr_ready), 64'd0);
      chk("sweep_done", 64'(clr_done), 64'd0);
      chk_all("sweep_q");
      @(negedge clk);
    end
    chk("end_busy", 64'(clr_busy), 64'd0);
    chk("end_done", 64'(clr_done), 64'd1);
    chk("end_ready", 64'(bus.wr_ready), 64'd1);
    chk_all("end_q");
    @(negedge clk);
    chk("done_single", 64'(clr_done), 64'd0);

    // Write and clear on the same edge; second request ignored.
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = 64'h55;
    clr_req      = 1'b1;
    e.addr = 5'd7;
    e.data = 64'h55;
    exp_q.push_back(e);
    done_q.push_back(2);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    clr_req      = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      if (k == 7) chk("q7_before", q[7], 64'h55);
      if (k == 8) chk("q7_cleared", q[7], 64'd0);
      if (k == 10) clr_req = 1'b1;
      if (k == 11) clr_req = 1'b0;
      if (k == 31) chk("busy_31", 64'(clr_busy), 64'd1);
      if (k == 32) begin
        chk("busy_32", 64'(clr_busy), 64'd0);
        chk("done_32", 64'(clr_done), 64'd1);
      end else begin
        @(negedge clk);
      end
    end
    mdl[7] = '0;
    chk_all("after_second");

    // Reset in mid-sweep with a write held.
    do_write(5'd20, 64'h2020);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k == 2) begin
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd9;
        bus.wr_data  = 64'h99;
        e.addr = 5'd9;
        e.data = 64'h99;
        exp_q.push_back(e);
      end
      if (k == 9) chk("q20_pre_rst", q[20], 64'h2020);
      if (k == 10) begin
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        chk_all("rst_q");
        chk("rst_busy", 64'(clr_busy), 64'd0);
        chk("rst_done", 64'(clr_done), 64'd0);
        chk("rst_ready", 64'(bus.wr_ready), 64'd1);
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    wait_accept("held");
    mdl[9] = 64'h99;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk_all("held_q");

    // Same-cycle visibility depends on the bypass build.
    do_write(5'd12, 64'hA5A5);
    chk_all("bypass_after");

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
